// File: rtl/simd_pkg.sv
// Shared types for the SIMD issue scheduler: opcodes, FSM states,
// and the registered issue record broadcast to the lanes.
package simd_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_OR  = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        opcode_e    opcode;
    } issue_tag_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Produces a one-hot grant plus an any-request flag.
module rr_pick
    import simd_pkg::*;
#(
    parameter int W  = 4,
    parameter int PW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [W-1:0]  grant,
    output logic          any
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < W; i++) begin
            int j;
            j = (int'(ptr) + i) % W;
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/simd_issue_sched.sv
// Credit-based SIMD issue scheduler with per-lane reservation tracking.
// Optional counters: define SIMD_SCHED_STATS_EN for stat_issued/stat_stall.
module simd_issue_sched
    import simd_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int RS_SIZE = 4,
    parameter int NREQ    = 2,
    parameter int LW = (LANES > 1) ? $clog2(LANES) : 1,
    parameter int RW = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][7:0]       req_a,
    input  logic [NREQ-1:0][7:0]       req_b,
    input  logic [NREQ-1:0][2:0]       req_opcode,
    output logic [NREQ-1:0]            req_ready,
    output logic [LANES-1:0]           lane_instr_valid,
    output logic [7:0]                 lane_a,
    output logic [7:0]                 lane_b,
    output logic [2:0]                 lane_opcode,
    output logic                       issue_tag_valid,
    output logic [RW-1:0]              issue_tag_req,
    output logic [LW-1:0]              issue_tag_lane,
    output logic [IW-1:0]              issue_tag_idx,
    input  logic [LANES-1:0]           lane_done,
    input  logic                       rdy_valid,
    input  logic [LW-1:0]              rdy_lane,
    input  logic [IW-1:0]              rdy_idx,
    output logic [LANES-1:0]           mark_ready_valid,
    output logic [LANES-1:0][IW-1:0]   mark_ready_idx,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic                       err
`ifdef SIMD_SCHED_STATS_EN
    ,
    output logic [31:0]                stat_issued,
    output logic [31:0]                stat_stall
`endif
);

    localparam int CW = $clog2(RS_SIZE + 1);

    logic [CW-1:0]      credit [LANES];
    logic [IW-1:0]      tail   [LANES];
    logic [IW-1:0]      head   [LANES];
    logic [RS_SIZE-1:0] bitmap [LANES];
    logic [RS_SIZE-1:0] bitmap_nx [LANES];

    logic [LW-1:0]    lane_ptr;
    logic [RW-1:0]    req_ptr;
    sched_state_e     state;
    sched_state_e     state_nx;

    logic [LANES-1:0] lane_elig;
    logic [LANES-1:0] lane_gnt;
    logic [LANES-1:0] lane_acc;
    logic [LANES-1:0] done_ok;
    logic             lane_any;
    logic [NREQ-1:0]  req_gnt;
    logic             req_any;
    logic             accept;
    logic [LW-1:0]    lane_sel;
    logic [RW-1:0]    req_sel;
    logic             credits_zero;
    logic             bad_done;
    logic             rdy_hit;
    logic             rdy_bad;
    issue_tag_t       issue_q;

    always_comb begin
        lane_elig    = '0;
        done_ok      = '0;
        credits_zero = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            lane_elig[l] = credit[l] < CW'(RS_SIZE);
            done_ok[l]   = lane_done[l] && (credit[l] != '0);
            if (credit[l] != '0) credits_zero = 1'b0;
        end
    end

    assign bad_done = |(lane_done & ~done_ok);

    rr_pick #(.W(LANES), .PW(LW)) u_lane_pick (
        .req   (lane_elig),
        .ptr   (lane_ptr),
        .grant (lane_gnt),
        .any   (lane_any)
    );

    rr_pick #(.W(NREQ), .PW(RW)) u_req_pick (
        .req   (req_valid),
        .ptr   (req_ptr),
        .grant (req_gnt),
        .any   (req_any)
    );

    // req_any is implied by a nonzero req_gnt; kept for the picker contract
    assign req_ready = (state == ST_RUN && lane_any && req_any) ? req_gnt : '0;
    assign accept    = |req_ready;
    assign lane_acc  = accept ? lane_gnt : '0;

    always_comb begin
        lane_sel = '0;
        req_sel  = '0;
        for (int l = 0; l < LANES; l++)
            if (lane_gnt[l]) lane_sel = LW'(l);
        for (int r = 0; r < NREQ; r++)
            if (req_gnt[r]) req_sel = RW'(r);
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            bitmap_nx[l] = bitmap[l];
            if (done_ok[l]) bitmap_nx[l][head[l]] = 1'b0;
            if (lane_acc[l]) bitmap_nx[l][tail[l]] = 1'b1;
        end
    end

    assign rdy_hit = rdy_valid && (int'(rdy_lane) < LANES)
                     && bitmap[rdy_lane][rdy_idx];
    assign rdy_bad = rdy_valid && !rdy_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < LANES; l++) begin
                credit[l] <= '0;
                tail[l]   <= '0;
                head[l]   <= '0;
                bitmap[l] <= '0;
            end
            lane_ptr         <= '0;
            req_ptr          <= '0;
            lane_instr_valid <= '0;
            issue_q          <= '0;
            issue_tag_valid  <= 1'b0;
            issue_tag_req    <= '0;
            issue_tag_lane   <= '0;
            issue_tag_idx    <= '0;
            mark_ready_valid <= '0;
            mark_ready_idx   <= '0;
            err              <= 1'b0;
        end else begin
            lane_instr_valid <= lane_acc;
            issue_tag_valid  <= accept;
            if (accept) begin
                issue_q.a      <= req_a[req_sel];
                issue_q.b      <= req_b[req_sel];
                issue_q.opcode <= opcode_e'(req_opcode[req_sel]);
                issue_tag_req  <= req_sel;
                issue_tag_lane <= lane_sel;
                issue_tag_idx  <= tail[lane_sel];
                req_ptr  <= (int'(req_sel) == NREQ - 1) ? '0 : req_sel + 1'b1;
                lane_ptr <= (int'(lane_sel) == LANES - 1) ? '0 : lane_sel + 1'b1;
            end
            // RS_SIZE is a power of two, so pointers wrap naturally
            for (int l = 0; l < LANES; l++) begin
                credit[l] <= credit[l] + CW'(lane_acc[l]) - CW'(done_ok[l]);
                bitmap[l] <= bitmap_nx[l];
                if (lane_acc[l]) tail[l] <= tail[l] + 1'b1;
                if (done_ok[l]) head[l] <= head[l] + 1'b1;
            end
            mark_ready_valid <= '0;
            if (rdy_hit) begin
                mark_ready_valid[rdy_lane] <= 1'b1;
                mark_ready_idx[rdy_lane]   <= rdy_idx;
            end
            if (bad_done || rdy_bad) err <= 1'b1;
        end
    end

    assign lane_a      = issue_q.a;
    assign lane_b      = issue_q.b;
    assign lane_opcode = issue_q.opcode;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        flush_done = 1'b0;
        unique case (state)
            ST_RUN:   if (flush_req) state_nx = ST_DRAIN;
            ST_DRAIN: if (credits_zero && !(|lane_instr_valid)) state_nx = ST_DONE;
            ST_DONE: begin
                flush_done = 1'b1;
                state_nx   = ST_RUN;
            end
            default:  state_nx = ST_RUN;
        endcase
    end

`ifdef SIMD_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (accept) stat_issued <= stat_issued + 32'd1;
            if (|req_valid && !accept) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_simd_issue_sched.sv
// Directed plus random bench for simd_issue_sched against a queue-based
// reference model; stats are checked when SIMD_SCHED_STATS_EN is defined.
module tb_simd_issue_sched;

    localparam int LANES = 4;
    localparam int RS    = 4;
    localparam int NREQ  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0][7:0] req_a;
    logic [NREQ-1:0][7:0] req_b;
    logic [NREQ-1:0][2:0] req_opcode;
    logic [NREQ-1:0]      req_ready;
    logic [LANES-1:0]     lane_instr_valid;
    logic [7:0]           lane_a;
    logic [7:0]           lane_b;
    logic [2:0]           lane_opcode;
    logic                 issue_tag_valid;
    logic [0:0]           issue_tag_req;
    logic [1:0]           issue_tag_lane;
    logic [1:0]           issue_tag_idx;
    logic [LANES-1:0]     lane_done;
    logic                 rdy_valid;
    logic [1:0]           rdy_lane;
    logic [1:0]           rdy_idx;
    logic [LANES-1:0]     mark_ready_valid;
    logic [LANES-1:0][1:0] mark_ready_idx;
    logic                 flush_req;
    logic                 flush_done;
    logic                 err;
`ifdef SIMD_SCHED_STATS_EN
    logic [31:0]          stat_issued;
    logic [31:0]          stat_stall;
`endif

    simd_issue_sched #(.LANES(LANES), .RS_SIZE(RS), .NREQ(NREQ)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_opcode       (req_opcode),
        .req_ready        (req_ready),
        .lane_instr_valid (lane_instr_valid),
        .lane_a           (lane_a),
        .lane_b           (lane_b),
        .lane_opcode      (lane_opcode),
        .issue_tag_valid  (issue_tag_valid),
        .issue_tag_req    (issue_tag_req),
        .issue_tag_lane   (issue_tag_lane),
        .issue_tag_idx    (issue_tag_idx),
        .lane_done        (lane_done),
        .rdy_valid        (rdy_valid),
        .rdy_lane         (rdy_lane),
        .rdy_idx          (rdy_idx),
        .mark_ready_valid (mark_ready_valid),
        .mark_ready_idx   (mark_ready_idx),
        .flush_req        (flush_req),
        .flush_done       (flush_done),
        .err              (err)
`ifdef SIMD_SCHED_STATS_EN
        ,
        .stat_issued      (stat_issued),
        .stat_stall       (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: each lane is a queue of outstanding slot indices.
    int mq [LANES][$];
    int mtail [LANES];
    int lptr, rptr, mst;
    bit merr;
    int e_liv, e_treq, e_tlane, e_tidx, e_mrv, e_mri;
    int e_a, e_b, e_op;
    int unsigned s_iss, s_stall;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < LANES; l++) begin
            mq[l].delete();
            mtail[l] = 0;
        end
        lptr = 0; rptr = 0; mst = 0; merr = 0;
        e_liv = -1; e_treq = 0; e_tlane = 0; e_tidx = 0;
        e_mrv = -1; e_mri = 0;
        e_a = 0; e_b = 0; e_op = 0;
        s_iss = 0; s_stall = 0;
    endtask

    task automatic tick();
        int lsel, rsel, nst, new_mrv;
        bit acc, empty, pend, hit;
        logic [NREQ-1:0] exp_ready;
        #2;
        if (reset) begin
            model_reset();
        end else begin
            lsel = -1; rsel = -1;
            for (int k = 0; k < LANES; k++)
                if (lsel < 0 && mq[(lptr + k) % LANES].size() < RS)
                    lsel = (lptr + k) % LANES;
            for (int k = 0; k < NREQ; k++)
                if (rsel < 0 && req_valid[(rptr + k) % NREQ])
                    rsel = (rptr + k) % NREQ;
            acc = (mst == 0) && lsel >= 0 && rsel >= 0;
            exp_ready = acc ? NREQ'(1 << rsel) : '0;
            chk("req_ready", req_ready, exp_ready);
            chk("ready_onehot", $countones(req_ready) <= 1, 1);
            empty = 1;
            for (int l = 0; l < LANES; l++)
                if (mq[l].size() != 0) empty = 0;
            pend = e_liv >= 0;
            new_mrv = -1;
            if (rdy_valid) begin
                hit = 0;
                for (int k = 0; k < mq[rdy_lane].size(); k++)
                    if (mq[rdy_lane][k] == int'(rdy_idx)) hit = 1;
                if (hit) begin
                    new_mrv = rdy_lane;
                    e_mri   = rdy_idx;
                end else merr = 1;
            end
            for (int l = 0; l < LANES; l++)
                if (lane_done[l]) begin
                    if (mq[l].size() == 0) merr = 1;
                    else void'(mq[l].pop_front());
                end
            nst = mst;
            if (mst == 0 && flush_req) nst = 1;
            if (mst == 1 && empty && !pend) nst = 2;
            if (mst == 2) nst = 0;
            if (acc) begin
                mq[lsel].push_back(mtail[lsel]);
                e_tidx = mtail[lsel];
                mtail[lsel] = (mtail[lsel] + 1) % RS;
                e_liv = lsel; e_tlane = lsel; e_treq = rsel;
                e_a = req_a[rsel]; e_b = req_b[rsel]; e_op = req_opcode[rsel];
                rptr = (rsel + 1) % NREQ;
                lptr = (lsel + 1) % LANES;
                s_iss++;
            end else e_liv = -1;
            if (|req_valid && !acc) s_stall++;
            e_mrv = new_mrv;
            mst = nst;
        end
        @(posedge clk);
        #1;
        chk("lane_instr_valid", lane_instr_valid,
            e_liv >= 0 ? LANES'(1 << e_liv) : '0);
        chk("issue_tag_valid", issue_tag_valid, e_liv >= 0);
        chk("lane_a", lane_a, e_a);
        chk("lane_b", lane_b, e_b);
        chk("lane_opcode", lane_opcode, e_op);
        if (e_liv >= 0) begin
            chk("tag_req", issue_tag_req, e_treq);
            chk("tag_lane", issue_tag_lane, e_tlane);
            chk("tag_idx", issue_tag_idx, e_tidx);
        end
        chk("mark_ready_valid", mark_ready_valid,
            e_mrv >= 0 ? LANES'(1 << e_mrv) : '0);
        if (e_mrv >= 0) chk("mark_ready_idx", mark_ready_idx[e_mrv], e_mri);
        chk("err", err, merr);
        chk("flush_done", flush_done, mst == 2);
    endtask

    task automatic idle();
        reset = 0; req_valid = '0; lane_done = '0;
        rdy_valid = 0; rdy_lane = '0; rdy_idx = '0; flush_req = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        idle();
        req_a = '0; req_b = '0; req_opcode = '0;
        model_reset();
        do_reset();

        // Requester 0 alone, ADD 3,5: lanes 0..3, all at slot 0
        req_valid = 2'b01; req_a[0] = 8'd3; req_b[0] = 8'd5; req_opcode[0] = 3'b000;
        repeat (4) tick();
        req_valid = '0;
        tick();

        // Both requesters every cycle: grants alternate
        do_reset();
        req_valid = 2'b11; req_a[1] = 8'd9; req_b[1] = 8'd1; req_opcode[1] = 3'b100;
        repeat (8) tick();
        idle();
        tick();

        // Fill all 16 slots, stall, free lane 2 and refill slot 0
        do_reset();
        req_valid = 2'b01;
        repeat (18) tick();
        req_valid = '0; lane_done = 4'b0100;
        tick();
        lane_done = '0; req_valid = 2'b01;
        tick();
        req_valid = '0;
        tick();

        // Ready notices: allocated slot pulses, unallocated slot errors
        do_reset();
        req_valid = 2'b01;
        repeat (2) tick();
        req_valid = '0; rdy_valid = 1; rdy_lane = 2'd1; rdy_idx = 2'd0;
        tick();
        rdy_lane = 2'd3; rdy_idx = 2'd2;
        tick();
        rdy_valid = 0;
        tick();

        // Drain with three outstanding entries
        do_reset();
        req_valid = 2'b01;
        repeat (3) tick();
        req_valid = '0; flush_req = 1;
        tick();
        flush_req = 0; req_valid = 2'b10;
        tick();
        lane_done = 4'b0001; tick();
        lane_done = 4'b0010; tick();
        lane_done = 4'b0100; tick();
        lane_done = '0;
        repeat (4) tick();
        idle();
        tick();

        // Accept and retire on lane 0 together, then reset mid-drain
        do_reset();
        req_valid = 2'b01;
        repeat (4) tick();
        lane_done = 4'b0001;
        tick();
        lane_done = '0; req_valid = '0; flush_req = 1;
        tick();
        flush_req = 0;
        repeat (2) tick();
        reset = 1;
        tick();
        reset = 0; req_valid = 2'b01;
        repeat (2) tick();

        // Random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset      = ($urandom_range(0, 199) == 0);
            req_valid  = NREQ'($urandom_range(0, 3));
            for (int r = 0; r < NREQ; r++) begin
                req_a[r]      = 8'($urandom);
                req_b[r]      = 8'($urandom);
                req_opcode[r] = 3'($urandom_range(0, 4));
            end
            for (int l = 0; l < LANES; l++)
                lane_done[l] = ($urandom_range(0, 3) == 0);
            rdy_valid = ($urandom_range(0, 2) == 0);
            rdy_lane  = 2'($urandom);
            rdy_idx   = 2'($urandom);
            flush_req = ($urandom_range(0, 39) == 0);
            tick();
        end
        idle();
        tick();

`ifdef SIMD_SCHED_STATS_EN
        chk("stat_issued", stat_issued, s_iss);
        chk("stat_stall", stat_stall, s_stall);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
